// File: rtl/cpu_run_monitor_pkg.sv
// Shared state encoding and run-result codes for the CPU run monitor.
package cpu_run_monitor_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_HALT    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_STALL   = 2'b11;

endpackage

// File: rtl/run_mon_stall_det.sv
// Stall detector (built only with CPU_RUN_MONITOR_STALL_DET_EN): flags a RUN cycle whose pc
// completes STALL_LIMIT identical consecutive samples; combinational flag, no backpressure.
module run_mon_stall_det
   import cpu_run_monitor_pkg::*;
#(
   parameter int unsigned STALL_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        cpu_hlt,
   input  logic [15:0] cpu_pc,
   output logic        stall
);

   logic [15:0] prev_pc;
   logic        prev_vld;
   logic [7:0]  cnt;
   logic        same;

   // The first RUN cycle only primes prev_pc; prev_vld blocks a false match against stale data.
   assign same  = prev_vld && (cpu_pc == prev_pc) && !cpu_hlt;
   assign stall = en && same && (cnt == 8'(STALL_LIMIT - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_pc  <= '0;
         prev_vld <= 1'b0;
         cnt      <= '0;
      end else if (clr) begin
         prev_pc  <= '0;
         prev_vld <= 1'b0;
         cnt      <= '0;
      end else if (en) begin
         prev_pc  <= cpu_pc;
         prev_vld <= 1'b1;
         cnt      <= same ? cnt + 8'd1 : 8'd0;
      end
   end

endmodule

// File: rtl/cpu_run_monitor.sv
// Sequences reset/run of a CPU under test and reports HALT, TIMEOUT or (with
// CPU_RUN_MONITOR_STALL_DET_EN) STALL; results register one edge after the deciding RUN cycle.
module cpu_run_monitor
   import cpu_run_monitor_pkg::*;
#(
   parameter int unsigned RST_CYCLES  = 2,
   parameter int unsigned TIMEOUT     = 20,
   parameter int unsigned STALL_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        cpu_rst_n,
   input  logic        cpu_hlt,
   input  logic [15:0] cpu_pc,
   output logic        done,
   output logic [1:0]  status,
   output logic [15:0] cycle_count,
   output logic [15:0] last_pc
);

   state_t      state, state_nxt;
   logic [3:0]  rst_cnt;
   logic        start_ok;
   logic        run;
   logic        stall_hit;
   logic        timeout_hit;
   logic [16:0] cc_inc;

   assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
   assign run         = (state == S_RUN);
   assign cc_inc      = {1'b0, cycle_count} + 17'd1;
   assign timeout_hit = run && (cc_inc == 17'(TIMEOUT));
   assign cpu_rst_n   = (state == S_RUN) || (state == S_DONE);
   assign done        = (state == S_DONE);

`ifdef CPU_RUN_MONITOR_STALL_DET_EN
   run_mon_stall_det #(
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start_ok),
      .en      (run),
      .cpu_hlt (cpu_hlt),
      .cpu_pc  (cpu_pc),
      .stall   (stall_hit)
   );
`else
   assign stall_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_RESET;
         S_RESET:        if (rst_cnt == 4'(RST_CYCLES - 1)) state_nxt = S_RUN;
         S_RUN:          if (cpu_hlt || stall_hit || timeout_hit) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Termination priority is encoded by the if/else order: HALT, then STALL, then TIMEOUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt     <= '0;
         status      <= ST_NONE;
         cycle_count <= '0;
         last_pc     <= '0;
      end else if (start_ok) begin
         rst_cnt     <= '0;
         status      <= ST_NONE;
         cycle_count <= '0;
         last_pc     <= '0;
      end else if (state == S_RESET) begin
         rst_cnt <= rst_cnt + 4'd1;
      end else if (run) begin
         cycle_count <= cc_inc[15:0];
         last_pc     <= cpu_pc;
         if (cpu_hlt)          status <= ST_HALT;
         else if (stall_hit)   status <= ST_STALL;
         else if (timeout_hit) status <= ST_TIMEOUT;
      end
   end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomised self-checking bench for cpu_run_monitor against a run-length outcome model.
module tb_cpu_run_monitor;

   localparam int RST_CYCLES  = 2;
   localparam int TIMEOUT     = 20;
   localparam int STALL_LIMIT = 8;
   localparam int MAXK        = TIMEOUT + 4;
`ifdef CPU_RUN_MONITOR_STALL_DET_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        cpu_rst_n;
   logic        cpu_hlt;
   logic [15:0] cpu_pc;
   logic        done;
   logic [1:0]  status;
   logic [15:0] cycle_count;
   logic [15:0] last_pc;

   logic [15:0] stim_pc  [1:MAXK];
   bit          stim_hlt [1:MAXK];

   logic [1:0]  clr_status;
   logic [15:0] clr_cc;
   logic [15:0] clr_pc;
   logic        clr_done;
   logic        clr_cpu_rst_n;

   int n_cmp;
   int n_bad;

   cpu_run_monitor #(
      .RST_CYCLES  (RST_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .STALL_LIMIT (STALL_LIMIT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cpu_rst_n   (cpu_rst_n),
      .cpu_hlt     (cpu_hlt),
      .cpu_pc      (cpu_pc),
      .done        (done),
      .status      (status),
      .cycle_count (cycle_count),
      .last_pc     (last_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outcome of one run from the stimulus tables: the length of the current equal-pc streak decides STALL.
   function automatic void model(output logic [1:0] st, output int cc, output logic [15:0] lp);
      int streak;
      streak = 0;
      st = 2'b00;
      cc = 0;
      lp = '0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         cc = k;
         lp = stim_pc[k];
         if (k > 1 && stim_pc[k] == stim_pc[k-1]) streak++;
         else streak = 1;
         if (stim_hlt[k]) begin st = 2'b01; return; end
         if (STALL_EN && streak >= STALL_LIMIT) begin st = 2'b11; return; end
         if (k == TIMEOUT) begin st = 2'b10; return; end
      end
   endfunction

   // Starts a run and plays the tables as a CPU released from reset; start_at re-pulses start in RUN.
   task automatic do_run(input int start_at, output int rst_low, output logic got_done);
      int k;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clr_status = status; clr_cc = cycle_count; clr_pc = last_pc;
      clr_done = done; clr_cpu_rst_n = cpu_rst_n;
      rst_low = 0;
      for (int i = 0; i < 20 && !cpu_rst_n; i++) begin
         rst_low++;
         @(posedge clk); #1;
      end
      k = 1;
      while (!done && cpu_rst_n && k <= MAXK) begin
         cpu_pc  = stim_pc[k];
         cpu_hlt = stim_hlt[k];
         start   = (k == start_at);
         @(posedge clk); #1;
         start = 1'b0;
         k++;
      end
      cpu_hlt = 1'b0;
      got_done = done;
   endtask

   task automatic test_reset();
      #2;
      n_cmp += 5;
      if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_rst_n got=%b want=0", cpu_rst_n); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
      if (status !== 2'b00) begin n_bad++; $display("FAIL reset_status got=%b want=00", status); end
      if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL reset_cycle_count got=%0d want=0", cycle_count); end
      if (last_pc !== 16'd0) begin n_bad++; $display("FAIL reset_last_pc got=%h want=0", last_pc); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle_hold cpu_rst_n=%b done=%b want 0/0", cpu_rst_n, done);
      end
   endtask

   task automatic test_halt();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int k = 1; k <= MAXK; k++) begin stim_pc[k] = 16'((k - 1) * 2); stim_hlt[k] = (k == 7); end
      model(es, ec, ep);
      do_run(0, rl, gd);
      n_cmp += 5;
      if (gd !== 1'b1) begin n_bad++; $display("FAIL halt_done got=%b want=1", gd); end
      if (status !== es) begin n_bad++; $display("FAIL halt_status got=%b want=%b", status, es); end
      if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL halt_cycle_count got=%0d want=%0d", cycle_count, ec); end
      if (last_pc !== ep) begin n_bad++; $display("FAIL halt_last_pc got=%h want=%h", last_pc, ep); end
      if (rl != RST_CYCLES) begin n_bad++; $display("FAIL halt_cpu_rst_len got=%0d want=%0d", rl, RST_CYCLES); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b1 || status !== es || cycle_count !== 16'(ec) || last_pc !== ep) begin
         n_bad++; $display("FAIL halt_hold done=%b status=%b cc=%0d pc=%h", done, status, cycle_count, last_pc);
      end
   endtask

   task automatic test_timeout();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int k = 1; k <= MAXK; k++) begin stim_pc[k] = 16'(k + 16'h0100); stim_hlt[k] = 1'b0; end
      model(es, ec, ep);
      do_run(0, rl, gd);
      n_cmp += 3;
      if (gd !== 1'b1) begin n_bad++; $display("FAIL timeout_done got=%b want=1", gd); end
      if (status !== es) begin n_bad++; $display("FAIL timeout_status got=%b want=%b", status, es); end
      if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL timeout_cycle_count got=%0d want=%0d", cycle_count, ec); end
   endtask

   task automatic test_stall();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int k = 1; k <= MAXK; k++) begin
         stim_pc[k] = (k < 3) ? 16'((k - 1) * 2) : 16'h0004;
         stim_hlt[k] = 1'b0;
      end
      model(es, ec, ep);
      do_run(0, rl, gd);
      n_cmp += 4;
      if (gd !== 1'b1) begin n_bad++; $display("FAIL stall_done got=%b want=1", gd); end
      if (status !== es) begin n_bad++; $display("FAIL stall_status got=%b want=%b", status, es); end
      if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL stall_cycle_count got=%0d want=%0d", cycle_count, ec); end
      if (last_pc !== ep) begin n_bad++; $display("FAIL stall_last_pc got=%h want=%h", last_pc, ep); end
   endtask

   task automatic test_priority();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int k = 1; k <= MAXK; k++) begin
         stim_pc[k] = (k < 13) ? 16'(k) : 16'h0040;
         stim_hlt[k] = (k == TIMEOUT);
      end
      model(es, ec, ep);
      do_run(0, rl, gd);
      n_cmp += 2;
      if (status !== es) begin n_bad++; $display("FAIL priority_status got=%b want=%b", status, es); end
      if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL priority_cycle_count got=%0d want=%0d", cycle_count, ec); end
   endtask

   task automatic test_start_during_run();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int k = 1; k <= MAXK; k++) begin stim_pc[k] = 16'(3 * k); stim_hlt[k] = (k == 12); end
      model(es, ec, ep);
      do_run(5, rl, gd);
      n_cmp += 3;
      if (status !== es) begin n_bad++; $display("FAIL start_in_run_status got=%b want=%b", status, es); end
      if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL start_in_run_cycle_count got=%0d want=%0d", cycle_count, ec); end
      if (last_pc !== ep) begin n_bad++; $display("FAIL start_in_run_last_pc got=%h want=%h", last_pc, ep); end
   endtask

   task automatic test_restart();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int k = 1; k <= MAXK; k++) begin stim_pc[k] = 16'h0200 + 16'(k); stim_hlt[k] = (k == 4); end
      model(es, ec, ep);
      do_run(0, rl, gd);
      n_cmp += 7;
      if (clr_status !== 2'b00) begin n_bad++; $display("FAIL restart_clear_status got=%b want=00", clr_status); end
      if (clr_cc !== 16'd0) begin n_bad++; $display("FAIL restart_clear_cycle_count got=%0d want=0", clr_cc); end
      if (clr_pc !== 16'd0) begin n_bad++; $display("FAIL restart_clear_last_pc got=%h want=0", clr_pc); end
      if (clr_done !== 1'b0 || clr_cpu_rst_n !== 1'b0) begin
         n_bad++; $display("FAIL restart_clear_ctrl done=%b cpu_rst_n=%b want 0/0", clr_done, clr_cpu_rst_n);
      end
      if (rl != RST_CYCLES) begin n_bad++; $display("FAIL restart_cpu_rst_len got=%0d want=%0d", rl, RST_CYCLES); end
      if (status !== es) begin n_bad++; $display("FAIL restart_status got=%b want=%b", status, es); end
      if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL restart_cycle_count got=%0d want=%0d", cycle_count, ec); end
   endtask

   task automatic test_async_reset();
      int run_cycles;
      run_cycles = 4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (RST_CYCLES + run_cycles) begin
         cpu_pc = cpu_pc + 16'd1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (cycle_count !== 16'(run_cycles) || cpu_rst_n !== 1'b1) begin
         n_bad++; $display("FAIL areset_prerun cc=%0d cpu_rst_n=%b want=%0d/1", cycle_count, cpu_rst_n, run_cycles);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp += 2;
      if (cpu_rst_n !== 1'b0 || done !== 1'b0 || status !== 2'b00) begin
         n_bad++; $display("FAIL areset_ctrl cpu_rst_n=%b done=%b status=%b want 0", cpu_rst_n, done, status);
      end
      if (cycle_count !== 16'd0 || last_pc !== 16'd0) begin
         n_bad++; $display("FAIL areset_data cc=%0d last_pc=%h want 0", cycle_count, last_pc);
      end
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (cpu_rst_n !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0) begin
         n_bad++; $display("FAIL areset_idle cpu_rst_n=%b done=%b cc=%0d want 0", cpu_rst_n, done, cycle_count);
      end
   endtask

   task automatic test_random();
      int rl, ec; logic gd; logic [1:0] es; logic [15:0] ep;
      for (int it = 0; it < 12; it++) begin
         stim_pc[1] = 16'($urandom);
         stim_hlt[1] = ($urandom_range(0, 29) == 0);
         for (int k = 2; k <= MAXK; k++) begin
            stim_pc[k]  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : stim_pc[k-1];
            stim_hlt[k] = ($urandom_range(0, 29) == 0);
         end
         model(es, ec, ep);
         do_run(int'($urandom_range(0, 15)), rl, gd);
         n_cmp += 4;
         if (gd !== 1'b1) begin n_bad++; $display("FAIL rand%0d_done got=%b want=1", it, gd); end
         if (status !== es) begin n_bad++; $display("FAIL rand%0d_status got=%b want=%b", it, status, es); end
         if (cycle_count !== 16'(ec)) begin n_bad++; $display("FAIL rand%0d_cycle_count got=%0d want=%0d", it, cycle_count, ec); end
         if (last_pc !== ep) begin n_bad++; $display("FAIL rand%0d_last_pc got=%h want=%h", it, last_pc, ep); end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      cpu_hlt = 1'b0;
      cpu_pc  = '0;
      n_cmp   = 0;
      n_bad   = 0;
      test_reset();
      test_halt();
      test_timeout();
      test_stall();
      test_priority();
      test_start_during_run();
      test_restart();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
